fip_32_div: RTL and testbench

- Sequential signed Q16.16 fixed-point divider: quot = x / y.
- Companion to the combinational fip_32 add/sub blocks. Provides the inverse of multiplication for the ray-tracing datapath (reciprocals, barycentric normalisation).
- Radix-2 restoring division, one quotient bit per clock.
- Valid/ready handshakes on input and output; saturating result with overflow and divide-by-zero flags.

---
 rtl/fip_pkg.sv | 27 ++
 rtl/fip_32_div_if.sv | 27 ++
 rtl/fip_div_step.sv | 24 ++
 rtl/fip_32_div.sv | 128 ++++++++++++
 tb/tb_fip_32_div.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/fip_pkg.sv
// Shared constants, types and helpers for the Q16.16 fixed-point blocks.
package fip_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned FRAC  = 16;
  localparam int unsigned DVD_W = WIDTH + FRAC;
  localparam int unsigned CNT_W = $clog2(DVD_W + 1);

  localparam logic [WIDTH-1:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [WIDTH-1:0] Q_MIN = 32'h8000_0000;

  typedef logic signed [WIDTH-1:0] fip_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1) without wrap.
  function automatic logic [WIDTH-1:0] fip_abs(input fip_t v);
    logic [WIDTH-1:0] u;
    u = v;
    return u[WIDTH-1] ? (~u + WIDTH'(1)) : u;
  endfunction

endpackage

// File: rtl/fip_32_div_if.sv
// Operand / result handshake bundle for the fixed-point divider.
interface fip_32_div_if;
  import fip_pkg::*;

  logic in_valid;
  logic in_ready;
  fip_t x;
  fip_t y;
  logic out_valid;
  logic out_ready;
  fip_t quot;
  logic overflow;
  logic div_by_zero;

  // Producer/consumer side.
  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, quot, overflow, div_by_zero
  );

  // Divider side.
  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, quot, overflow, div_by_zero
  );

endinterface

// File: rtl/fip_div_step.sv
// One combinational radix-2 restoring division iteration.
module fip_div_step
  import fip_pkg::*;
(
  input  logic [WIDTH-1:0] rem_i,
  input  logic             next_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_next_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic           ge;

  // Shift in the next dividend bit and subtract when the divisor fits.
  // The remainder stays below the divisor, so WIDTH bits hold it.
  always_comb begin
    shifted    = {rem_i, next_bit_i};
    ge         = (shifted >= {1'b0, divisor_i});
    q_bit_o    = ge;
    rem_next_o = ge ? WIDTH'(shifted - {1'b0, divisor_i}) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/fip_32_div.sv
// Sequential signed Q16.16 divider: one quotient bit per clock, fixed latency,
// saturating result with overflow and divide-by-zero flags.
module fip_32_div
  import fip_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  fip_32_div_if.slave  bus
);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [DVD_W-1:0] dvd_q;
  logic [DVD_W-1:0] q_q;
  logic [WIDTH-1:0] ymag_q;
  logic             sign_q;
  logic             xneg_q;
  logic             yzero_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] quot_q;
  logic             ovf_q;
  logic             dz_q;

  logic [WIDTH-1:0] rem_d;
  logic             q_bit_d;
  logic [WIDTH-1:0] quot_d;
  logic             ovf_d;
  logic             dz_d;
  logic [WIDTH-1:0] q_low;

  fip_div_step u_step (
    .rem_i      (rem_q),
    .next_bit_i (dvd_q[DVD_W-1]),
    .divisor_i  (ymag_q),
    .rem_next_o (rem_d),
    .q_bit_o    (q_bit_d)
  );

  // Final formatting: sign application, saturation and zero-divisor override.
  always_comb begin
    q_low  = q_q[WIDTH-1:0];
    quot_d = sign_q ? (~q_low + WIDTH'(1)) : q_low;
    ovf_d  = 1'b0;
    dz_d   = 1'b0;
    if (yzero_q) begin
      dz_d   = 1'b1;
      quot_d = xneg_q ? Q_MIN : Q_MAX;
    end else if (!sign_q && (q_q > DVD_W'(Q_MAX))) begin
      ovf_d  = 1'b1;
      quot_d = Q_MAX;
    end else if (sign_q && (q_q > DVD_W'(Q_MIN))) begin
      ovf_d  = 1'b1;
      quot_d = Q_MIN;
    end
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      q_q         <= '0;
      ymag_q      <= '0;
      sign_q      <= 1'b0;
      xneg_q      <= 1'b0;
      yzero_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            sign_q     <= bus.x[WIDTH-1] ^ bus.y[WIDTH-1];
            xneg_q     <= bus.x[WIDTH-1];
            yzero_q    <= (bus.y == '0);
            ymag_q     <= fip_abs(bus.y);
            dvd_q      <= {fip_abs(bus.x), {FRAC{1'b0}}};
            q_q        <= '0;
            rem_q      <= '0;
            cnt_q      <= CNT_W'(DVD_W);
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          if (cnt_q != '0) begin
            rem_q <= rem_d;
            dvd_q <= {dvd_q[DVD_W-2:0], 1'b0};
            q_q   <= {q_q[DVD_W-2:0], q_bit_d};
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            quot_q      <= quot_d;
            ovf_q       <= ovf_d;
            dz_q        <= dz_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quot        = quot_q;
  assign bus.overflow    = ovf_q;
  assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_fip_32_div.sv
// Directed self-checking bench for the Q16.16 sequential divider.
module tb_fip_32_div;
  import fip_pkg::*;

  localparam int LAT = 49;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fip_32_div_if bus ();

  fip_32_div dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair for a single acceptance edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    bus.x        = a;
    bus.y        = b;
    bus.in_valid = 1'b1;
    step_clk();
    bus.in_valid = 1'b0;
  endtask

  // Edges until out_valid is seen; 0 means the bound expired.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      step_clk();
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    step_clk();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.x = '0;
    bus.y = '0;
    repeat (3) step_clk();
    reset = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.overflow, bus.div_by_zero} !== 4'b1000 || bus.quot !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: rdy/vld/ovf/dz=%b%b%b%b quot=%h, required 1000 quot=00000000",
               bus.in_ready, bus.out_valid, bus.overflow, bus.div_by_zero, bus.quot);
    end
  endtask

  task automatic test_arith();
    logic [31:0] vx   [11] = '{32'h0001_0000, 32'h0006_0000, 32'h0001_0000, 32'h7FFF_FFFF,
                               32'h8000_0000, 32'h8000_0000, 32'hFFFF_0000, 32'hFFFF_FFFF,
                               32'hFFFF_0000, 32'h0000_0000, 32'h0006_0000};
    logic [31:0] vy   [11] = '{32'h0001_0000, 32'hFFFE_0000, 32'h0003_0000, 32'h0000_8000,
                               32'h0001_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0002_0000,
                               32'h0000_0000, 32'h0000_0000, 32'h0002_0000};
    logic [31:0] vq   [11] = '{32'h0001_0000, 32'hFFFD_0000, 32'h0000_5555, 32'h7FFF_FFFF,
                               32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFE_0000, 32'h0000_0000,
                               32'h8000_0000, 32'h7FFF_FFFF, 32'h0003_0000};
    logic        vovf [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        vdz  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL arith_ready[%0d]: in_ready=%b, required 1", i, bus.in_ready);
      end
      start_op(vx[i], vy[i]);
      wait_valid(lat);
      checks++;
      if (lat != LAT) begin
        errors++;
        $display("FAIL arith_latency[%0d]: %0d edges, required %0d", i, lat, LAT);
      end
      checks++;
      if (bus.quot !== vq[i] || bus.overflow !== vovf[i] || bus.div_by_zero !== vdz[i]) begin
        errors++;
        $display("FAIL arith_result[%0d] %h/%h: quot=%h ovf=%b dz=%b, required quot=%h ovf=%b dz=%b",
                 i, vx[i], vy[i], bus.quot, bus.overflow, bus.div_by_zero, vq[i], vovf[i], vdz[i]);
      end
      consume();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL arith_release[%0d]: out_valid=%b in_ready=%b, required 0 1",
                 i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    start_op(32'h0006_0000, 32'h0002_0000);
    for (int i = 0; i < 10; i++) begin
      bus.x        = 32'h1234_5678;
      bus.y        = 32'h0000_0000;
      bus.in_valid = i[0];
      step_clk();
    end
    bus.in_valid = 1'b0;
    wait_valid(lat);
    checks++;
    if (lat != LAT - 10) begin
      errors++;
      $display("FAIL bp_latency: %0d edges after pulses, required %0d", lat, LAT - 10);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = i[0];
      bus.x        = 32'h0001_0000;
      bus.y        = 32'h0000_0000;
      step_clk();
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quot !== 32'h0003_0000 ||
          bus.overflow !== 1'b0 || bus.div_by_zero !== 1'b0) bad++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d unstable cycles (quot=%h vld=%b rdy=%b), required 0 (quot=00030000 vld=1 rdy=0)",
               bad, bus.quot, bus.out_valid, bus.in_ready);
    end
    consume();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
    end
    repeat (60) step_clk();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_ghost: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    int seen;
    start_op(32'h0006_0000, 32'hFFFE_0000);
    repeat (10) step_clk();
    reset = 1'b1;
    step_clk();
    reset = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.overflow, bus.div_by_zero} !== 4'b1000 || bus.quot !== 32'h0) begin
      errors++;
      $display("FAIL midcalc_reset: rdy/vld/ovf/dz=%b%b%b%b quot=%h, required 1000 quot=00000000",
               bus.in_ready, bus.out_valid, bus.overflow, bus.div_by_zero, bus.quot);
    end
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      step_clk();
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midcalc_partial: out_valid high %0d cycles after reset, required 0", seen);
    end
    start_op(32'h0001_0000, 32'h0001_0000);
    wait_valid(lat);
    checks++;
    if (lat != LAT || bus.quot !== 32'h0001_0000 || bus.overflow !== 1'b0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL midcalc_fresh: lat=%0d quot=%h ovf=%b dz=%b, required lat=%0d quot=00010000 ovf=0 dz=0",
               lat, bus.quot, bus.overflow, bus.div_by_zero, LAT);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.out_ready = 1'b1;
    start_op(32'h0001_0000, 32'h0003_0000);
    wait_valid(lat);
    checks++;
    if (lat != LAT || bus.quot !== 32'h0000_5555) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d quot=%h, required lat=%0d quot=00005555", lat, bus.quot, LAT);
    end
    step_clk();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: in_ready=%b out_valid=%b, required 1 0", bus.in_ready, bus.out_valid);
    end
    start_op(32'h8000_0000, 32'h0001_0000);
    wait_valid(lat);
    checks++;
    if (lat != LAT || bus.quot !== 32'h8000_0000 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d quot=%h ovf=%b, required lat=%0d quot=80000000 ovf=0",
               lat, bus.quot, bus.overflow, LAT);
    end
    step_clk();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
